// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for CPU load/store traffic. Accepts one byte, half or
//   word request over a valid/ready handshake, waits WAIT_CYCLES cycles, and
//   then presents a response over a second valid/ready handshake. The backing
//   store is a big-endian, byte-addressable array of DEPTH_WORDS 32-bit words.
//   Misaligned, out-of-range and illegal-size accesses are flagged in rsp_err.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   high only in IDLE (and never while reset is asserted)
//   req_write  in   1   1 = store, 0 = load
//   req_size   in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data, right-aligned
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   consumer takes the response
//   rsp_rdata  out  32  load data, right-aligned, zero-extended; 0 for stores/errors
//   rsp_err    out  1   misaligned, out-of-range or illegal-size access
// -----------------------------------------------------------------------------
module mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LAST  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // Latched request (data only, no reset needed)
   logic        wr_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   // Access currently being resolved: straight from the request port when the
   // request goes IDLE->RESP in one edge (WAIT_CYCLES=0), otherwise the latch.
   logic             acc_wr;
   logic [1:0]       acc_size;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [IDX_W-1:0] acc_idx;
   logic             acc_err;
   logic [31:0]      acc_word;
   logic             enter_resp;

   function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
      logic e;
      e = 1'b0;
      case (size)
         2'b01:   e = addr[0];
         2'b10:   e = (addr[1:0] != 2'b00);
         2'b11:   e = 1'b1;
         default: e = 1'b0;
      endcase
      if (addr >= BYTE_LIMIT) e = 1'b1;
      return e;
   endfunction

   // Big-endian lane extraction: byte offset 0 is bits [31:24].
   function automatic logic [31:0] lane_read(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off);
      logic [31:0] r;
      r = 32'd0;
      case (size)
         2'b00: begin
            case (off)
               2'b00:   r = {24'd0, word[31:24]};
               2'b01:   r = {24'd0, word[23:16]};
               2'b10:   r = {24'd0, word[15:8]};
               default: r = {24'd0, word[7:0]};
            endcase
         end
         2'b01:   r = off[1] ? {16'd0, word[15:0]} : {16'd0, word[31:16]};
         2'b10:   r = word;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Replace only the addressed bytes of a word with right-aligned store data.
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] wd);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00: begin
            case (off)
               2'b00:   r[31:24] = wd[7:0];
               2'b01:   r[23:16] = wd[7:0];
               2'b10:   r[15:8]  = wd[7:0];
               default: r[7:0]   = wd[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) r[15:0]  = wd[15:0];
            else        r[31:16] = wd[15:0];
         end
         2'b10:   r = wd;
         default: r = word;
      endcase
      return r;
   endfunction

   always_comb begin
      if (state_q == IDLE) begin
         acc_wr    = req_write;
         acc_size  = req_size;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end else begin
         acc_wr    = wr_q;
         acc_size  = size_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
      end
   end

   assign acc_idx  = acc_addr[IDX_W+1:2];
   assign acc_err  = access_err(acc_size, acc_addr);
   assign acc_word = acc_err ? 32'd0 : mem_q[acc_idx];

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            // Held low while reset is asserted even though the state is IDLE.
            req_ready = reset;
            cnt_d     = 4'd0;
            if (req_valid && reset) begin
               state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Load data and error status are captured on the edge entering RESP and
      // then held unchanged for as long as the response is back-pressured.
      if (state_d == RESP && state_q != RESP) begin
         enter_resp = 1'b1;
         err_d      = acc_err;
         rdata_d    = (acc_err || acc_wr) ? 32'd0 : lane_read(acc_word, acc_size, acc_addr[1:0]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (req_valid && req_ready) begin
         wr_q    <= req_write;
         size_q  <= req_size;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Store commits on the same edge that enters RESP; a store aborted by reset
   // while still in WAIT never reaches this edge.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_wr && !acc_err) begin
         mem_q[acc_idx] <= lane_merge(acc_word, acc_size, acc_addr[1:0], acc_wdata);
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, rsp_rdata;

   logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err;
   logic [1:0]  z_req_size;
   logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

   mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
      .req_size(z_req_size), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
      .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   int         total = 0;
   int         bad   = 0;
   exp_t       sb[$];
   logic [7:0] ref_mem [256];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: byte array, big-endian, updated only on legal stores.
   task automatic model(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output exp_t e);
      logic       err;
      logic [7:0] o;
      err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
            || (a >= 32'd256);
      o = a[7:0];
      e.err   = err;
      e.rdata = 32'd0;
      if (!err) begin
         if (wr) begin
            case (sz)
               2'b00: ref_mem[o] = wd[7:0];
               2'b01: begin ref_mem[o] = wd[15:8]; ref_mem[o+8'd1] = wd[7:0]; end
               default: begin
                  ref_mem[o]       = wd[31:24];
                  ref_mem[o+8'd1]  = wd[23:16];
                  ref_mem[o+8'd2]  = wd[15:8];
                  ref_mem[o+8'd3]  = wd[7:0];
               end
            endcase
         end else begin
            case (sz)
               2'b00:   e.rdata = {24'd0, ref_mem[o]};
               2'b01:   e.rdata = {16'd0, ref_mem[o], ref_mem[o+8'd1]};
               default: e.rdata = {ref_mem[o], ref_mem[o+8'd1], ref_mem[o+8'd2], ref_mem[o+8'd3]};
            endcase
         end
      end
   endtask

   // Drives a request and returns at the falling edge after the accept edge.
   task automatic req_phase(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input bit track);
      exp_t e;
      int   n;
      if (track) begin
         model(wr, sz, a, wd, e);
         sb.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Waits for the response (counting edges since accept), checks it, consumes it.
   task automatic rsp_phase(input int exp_lat, input string tag);
      exp_t e;
      int   lat;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic txn(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
      req_phase(wr, sz, a, wd, 1'b1);
      rsp_phase(3, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int n;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'hxx;
      reset = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_addr = 32'd0; req_wdata = 32'd0;
      rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_write = 1'b0; z_req_size = 2'b00; z_req_addr = 32'd0;
      z_req_wdata = 32'd0; z_rsp_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      reset = 1'b1;
      #1;
      chk("rst_rel_req_ready", 32'(req_ready), 32'd1);

      // Word round-trip
      txn(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, "t1_st");
      txn(1'b0, 2'b10, 32'h10, 32'd0, "t1_ld");

      // Byte/half lanes
      txn(1'b1, 2'b00, 32'h12, 32'h00000011, "t2_stb");
      txn(1'b0, 2'b10, 32'h10, 32'd0, "t2_ldw");
      txn(1'b0, 2'b01, 32'h12, 32'd0, "t2_ldh");
      txn(1'b0, 2'b00, 32'h10, 32'd0, "t2_ldb");

      // Errors and range boundary
      txn(1'b0, 2'b10, 32'h11, 32'd0, "t3_ldw_mis");
      txn(1'b1, 2'b01, 32'h13, 32'h0000BEEF, "t3_sth_mis");
      txn(1'b0, 2'b10, 32'h10, 32'd0, "t3_ldw_keep");
      txn(1'b0, 2'b10, 32'h100, 32'd0, "t3_ldw_oor");
      txn(1'b0, 2'b11, 32'h10, 32'd0, "t3_size11");
      txn(1'b1, 2'b10, 32'hFC, 32'h01020304, "t3_st_last");
      txn(1'b1, 2'b00, 32'hFF, 32'h0000007A, "t3_stb_last");
      txn(1'b0, 2'b10, 32'hFC, 32'd0, "t3_ldw_last");
      txn(1'b1, 2'b00, 32'h100, 32'h000000EE, "t3_stb_oor");

      // Backpressure
      req_phase(1'b0, 2'b10, 32'h10, 32'd0, 1'b1);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t4_valid", 32'(rsp_valid), 32'd1);
      begin
         exp_t e2;
         model(1'b0, 2'b00, 32'h11, 32'd0, e2);
         sb.push_back(e2);
      end
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
         chk("t4_hold_rdata", rsp_rdata, sb[0].rdata);
         chk("t4_hold_err", 32'(rsp_err), 32'(sb[0].err));
         chk("t4_hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      void'(sb.pop_front());
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("t4_idle_valid", 32'(rsp_valid), 32'd0);
      chk("t4_idle_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t4_accepted", 32'(req_ready), 32'd0);
      rsp_phase(3, "t4_next");

      // Reset during WAIT drops the store
      txn(1'b1, 2'b10, 32'h20, 32'h00000000, "t5_clr");
      txn(1'b0, 2'b10, 32'h10, 32'd0, "t5_pre");
      req_phase(1'b1, 2'b10, 32'h20, 32'h55555555, 1'b0);
      reset = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
      chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
      chk("t5_rst_rdata", rsp_rdata, 32'd0);
      chk("t5_rst_err", 32'(rsp_err), 32'd0);
      repeat (2) @(negedge clk);
      chk("t5_rst_hold_valid", 32'(rsp_valid), 32'd0);
      reset = 1'b1;
      #1;
      chk("t5_rel_req_ready", 32'(req_ready), 32'd1);
      txn(1'b0, 2'b10, 32'h20, 32'd0, "t5_ld");

      // Zero-wait build: back-to-back with rsp_ready held high
      @(negedge clk);
      z_req_valid = 1'b1; z_req_write = 1'b1; z_req_size = 2'b10; z_req_addr = 32'h0;
      z_req_wdata = 32'hA5A5A5A5; z_rsp_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (z_rsp_valid) cnt++;
         if (i == 0) chk("t6_lat1", 32'(z_rsp_valid), 32'd1);
      end
      chk("t6_rate", 32'(cnt), 32'd4);
      z_req_write = 1'b0;
      @(negedge clk);
      chk("t6_ld_valid", 32'(z_rsp_valid), 32'd1);
      chk("t6_ld_rdata", z_rsp_rdata, 32'hA5A5A5A5);
      chk("t6_ld_err", 32'(z_rsp_err), 32'd0);
      z_req_valid = 1'b0;
      @(negedge clk);
      z_rsp_ready = 1'b0;
      chk("t6_done_valid", 32'(z_rsp_valid), 32'd0);

      chk("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
